delay_line: RTL and testbench
=============================

DELAY_LINE -- requirements
Module: delay_line

Interface
REQ-001 Parameter CHANNELS, default 2: number of independent data lanes.
REQ-002 Parameter WIDTH, default 8: data bits per lane.
REQ-003 Parameter MAX_DELAY, default 16: deepest supported delay in cycles, at least 1.
REQ-004 Parameter DEFAULT_DELAY, default 4: delay in force after reset, 1..MAX_DELAY.
REQ-005 Port list SHALL be exactly REQ-006..REQ-015, in that order.
REQ-006 clk  in  1  sole clock; all state updates on rising edge.
REQ-007 reset  in  1  asynchronous, active-high reset.
REQ-008 delay_cfg  in  $clog2(MAX_DELAY+1)  requested delay in cycles.
REQ-009 delay_load  in  1  single-cycle strobe; captures delay_cfg.
REQ-010 data_in  in  CHANNELS*WIDTH  lane c occupies bits [c*WIDTH +: WIDTH].
REQ-011 valid_in  in  CHANNELS  per-lane valid tag.
REQ-012 data_out  out  CHANNELS*WIDTH  delayed data, same packing as data_in.
REQ-013 valid_out  out  CHANNELS  delayed valid tag.
REQ-014 delay_active  out  $clog2(MAX_DELAY+1)  delay currently in force.
REQ-015 filling  out  1  high while outputs are gated after reset or reload.

Function
REQ-016 Line SHALL advance every cycle regardless of valid_in; valid is a tag that travels with its data.
REQ-017 With delay D in force, the lane value sampled at edge k SHALL appear on data_out/valid_out from edge k+D-1 until edge k+D (D=1 means one register stage).
REQ-018 delay_load at edge L SHALL clamp delay_cfg: 0 gives 1, values above MAX_DELAY give MAX_DELAY; the result SHALL appear on delay_active after edge L.
REQ-019 FSM states are FILL and RUN; reset enters FILL with D=DEFAULT_DELAY.
REQ-020 delay_load in any state SHALL enter FILL and clear the fill counter.
REQ-021 In FILL, the counter SHALL increment each cycle; at count D-1 the state SHALL go to RUN, so outputs are gated for exactly D cycles after the load edge or reset release.
REQ-022 While in FILL, valid_out and data_out SHALL be all zero and filling SHALL be 1; in RUN, filling SHALL be 0 and the outputs SHALL follow the tap.
REQ-023 Line contents SHALL NOT be cleared on reload; gating alone suppresses stale samples.
REQ-024 The first ungated output after a load at edge L SHALL be the sample captured at edge L+1.
REQ-025 delay_load during FILL SHALL restart the fill with the new D; the old D SHALL be discarded.
REQ-026 Reloading the same D SHALL still run a full FILL.
REQ-027 Lanes SHALL be fully independent; no cross-lane data or valid coupling.

Reset
REQ-028 Reset assertion SHALL immediately zero data_out, valid_out and every line stage, set delay_active=DEFAULT_DELAY, set filling=1 and enter FILL.
REQ-029 Samples in flight at reset SHALL never be emitted after release.
REQ-030 delay_load asserted together with reset SHALL be ignored.

Structure
REQ-031 Package delay_pkg SHALL hold the FSM state enum and the clamp function for delay_cfg.
REQ-032 Sub-module delay_tap (one lane: WIDTH+1-bit shift register of MAX_DELAY stages with a runtime-selected tap) SHALL be instantiated CHANNELS times; the FSM and fill counter SHALL be shared in delay_line.

Verification (CHANNELS=2, WIDTH=8, MAX_DELAY=16, DEFAULT_DELAY=4)
REQ-033 Default delay: release reset, wait 4 cycles (filling falls), then drive a one-cycle lane 0 pulse 0xA5 with valid at edge k -> valid_out[0]=1 and data 0xA5 for exactly one cycle after edge k+3; otherwise 0.
REQ-034 Reload: delay_load with cfg=9 at edge L -> filling=1 and outputs 0 for 9 cycles; a pulse captured at edge L+1 is emitted after edge L+9; delay_active=9.
REQ-035 Clamp: cfg=0 -> delay_active=1 with one-cycle latency; cfg=31 -> delay_active=16 with 16-cycle latency.
REQ-036 Reload during FILL: cfg=9, then cfg=3 two cycles later -> FILL restarts and ends after 3 cycles; latency 3.
REQ-037 Reset mid-flight: pulse 0x3C in the line, assert reset before emission -> outputs 0 immediately; after release, no 0x3C and no valid_out appears within 20 cycles.
REQ-038 Lane independence: lane 0 gets 0x11 at edge k, lane 1 gets 0x22 at edge k+2, D=5 -> emitted after edges k+4 and k+6, each lane's other half zero-valid.

Source files
------------

// File: rtl/delay_pkg.sv
// Shared types and helpers for the multi-lane programmable delay line.
package delay_pkg;

    typedef enum logic [0:0] {
        FILL = 1'b0,
        RUN  = 1'b1
    } fill_state_t;

    // A zero delay is meaningless for a registered line, so it becomes one stage.
    function automatic logic [31:0] clampDelay(input logic [31:0] cfg,
                                               input logic [31:0] maxDelay);
        if (cfg == 32'd0) begin
            return 32'd1;
        end else if (cfg > maxDelay) begin
            return maxDelay;
        end else begin
            return cfg;
        end
    endfunction

endpackage

// File: rtl/delay_tap.sv
// One lane: a free-running {valid,data} shift register with a runtime-selected output tap.
module delay_tap #(
    parameter int WIDTH     = 8,
    parameter int MAX_DELAY = 16,
    parameter int DW        = $clog2(MAX_DELAY + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [DW-1:0]    delay_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             valid_i,
    output logic [WIDTH-1:0] data_o,
    output logic             valid_o
);

    logic [WIDTH:0] stage_q [MAX_DELAY];
    logic [WIDTH:0] tap;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < MAX_DELAY; i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            stage_q[0] <= {valid_i, data_i};
            for (int i = 1; i < MAX_DELAY; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    // Delay D is read from stage D-1, so D=1 is a single register stage.
    always_comb begin
        tap = stage_q[0];
        for (int i = 0; i < MAX_DELAY; i++) begin
            if (delay_i == DW'(i + 1)) begin
                tap = stage_q[i];
            end
        end
    end

    assign {valid_o, data_o} = tap;

endmodule

// File: rtl/delay_line.sv
// Multi-lane delay line with a shared fill FSM that gates outputs until the selected tap holds fresh data.
module delay_line
    import delay_pkg::*;
#(
    parameter int CHANNELS      = 2,
    parameter int WIDTH         = 8,
    parameter int MAX_DELAY     = 16,
    parameter int DEFAULT_DELAY = 4
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [$clog2(MAX_DELAY+1)-1:0]   delay_cfg,
    input  logic                             delay_load,
    input  logic [CHANNELS*WIDTH-1:0]        data_in,
    input  logic [CHANNELS-1:0]              valid_in,
    output logic [CHANNELS*WIDTH-1:0]        data_out,
    output logic [CHANNELS-1:0]              valid_out,
    output logic [$clog2(MAX_DELAY+1)-1:0]   delay_active,
    output logic                             filling
);

    localparam int DW = $clog2(MAX_DELAY + 1);

    fill_state_t state_q, state_d;
    logic [DW-1:0] count_q, count_d;
    logic [DW-1:0] delay_q, delay_d;

    logic [CHANNELS*WIDTH-1:0] laneData;
    logic [CHANNELS-1:0]       laneValid;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= FILL;
            count_q <= '0;
            delay_q <= DW'(DEFAULT_DELAY);
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            delay_q <= delay_d;
        end
    end

    // A load always restarts the fill so stale samples behind the new tap are never shown.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        delay_d = delay_q;
        if (delay_load) begin
            delay_d = DW'(clampDelay(32'(delay_cfg), 32'(MAX_DELAY)));
            state_d = FILL;
            count_d = '0;
        end else if (state_q == FILL) begin
            if (count_q == delay_q - DW'(1)) begin
                state_d = RUN;
            end else begin
                count_d = count_q + DW'(1);
            end
        end
    end

    genvar c;
    generate
        for (c = 0; c < CHANNELS; c++) begin : g_lane
            delay_tap #(
                .WIDTH     (WIDTH),
                .MAX_DELAY (MAX_DELAY),
                .DW        (DW)
            ) u_tap (
                .clk     (clk),
                .reset   (reset),
                .delay_i (delay_q),
                .data_i  (data_in[c*WIDTH +: WIDTH]),
                .valid_i (valid_in[c]),
                .data_o  (laneData[c*WIDTH +: WIDTH]),
                .valid_o (laneValid[c])
            );
        end
    endgenerate

    assign filling      = (state_q == FILL);
    assign delay_active = delay_q;
    assign data_out     = filling ? '0 : laneData;
    assign valid_out    = filling ? '0 : laneValid;

endmodule

// File: tb/tb_delay_line.sv
// Directed self-checking bench for delay_line with two 8-bit lanes and a 16-deep line.
module tb_delay_line;

    logic        clk;
    logic        reset;
    logic [4:0]  delay_cfg;
    logic        delay_load;
    logic [15:0] data_in;
    logic [1:0]  valid_in;
    logic [15:0] data_out;
    logic [1:0]  valid_out;
    logic [4:0]  delay_active;
    logic        filling;

    int checks   = 0;
    int failures = 0;

    delay_line #(
        .CHANNELS      (2),
        .WIDTH         (8),
        .MAX_DELAY     (16),
        .DEFAULT_DELAY (4)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .delay_cfg    (delay_cfg),
        .delay_load   (delay_load),
        .data_in      (data_in),
        .valid_in     (valid_in),
        .data_out     (data_out),
        .valid_out    (valid_out),
        .delay_active (delay_active),
        .filling      (filling)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change and outputs are sampled 1ns after each rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [23:0] expv;
        reset = 1'b1; delay_load = 1'b0; delay_cfg = 5'd0;
        data_in = 16'hFFFF; valid_in = 2'b11;
        tick(); tick();
        checks++;
        expv = {1'b1, 2'b00, 16'h0000, 5'd4};
        if ({filling, valid_out, data_out, delay_active} !== expv) begin
            failures++;
            $display("[TB] FAIL reset_state got=%h exp=%h", {filling, valid_out, data_out, delay_active}, expv);
        end
        data_in = 16'h0; valid_in = 2'b00; reset = 1'b0;
        for (int j = 1; j <= 4; j++) begin
            tick();
            checks++;
            expv = {5'd0, 1'(j < 4), 2'b00, 16'h0000};
            if ({5'd0, filling, valid_out, data_out} !== expv) begin
                failures++;
                $display("[TB] FAIL reset_fill j=%0d got=%h exp=%h", j, {5'd0, filling, valid_out, data_out}, expv);
            end
        end
    endtask

    task automatic test_default_delay();
        logic [18:0] expv;
        for (int j = 0; j <= 5; j++) begin
            data_in  = (j == 0) ? 16'h00A5 : 16'h0;
            valid_in = (j == 0) ? 2'b01 : 2'b00;
            tick();
            expv = (j == 3) ? {1'b0, 2'b01, 16'h00A5} : 19'h0;
            checks++;
            if ({filling, valid_out, data_out} !== expv) begin
                failures++;
                $display("[TB] FAIL default_delay j=%0d got=%h exp=%h", j, {filling, valid_out, data_out}, expv);
            end
        end
    endtask

    task automatic test_reload();
        logic [18:0] expv;
        delay_cfg = 5'd9; delay_load = 1'b1;
        tick();
        delay_load = 1'b0;
        checks++;
        if ({filling, delay_active} !== {1'b1, 5'd9}) begin
            failures++;
            $display("[TB] FAIL reload_load got=%h exp=%h", {filling, delay_active}, {1'b1, 5'd9});
        end
        for (int j = 1; j <= 10; j++) begin
            data_in  = (j == 1) ? 16'h005A : 16'h0;
            valid_in = (j == 1) ? 2'b01 : 2'b00;
            tick();
            expv = (j == 9) ? {1'b0, 2'b01, 16'h005A} : {1'(j < 9), 2'b00, 16'h0000};
            checks++;
            if ({filling, valid_out, data_out} !== expv) begin
                failures++;
                $display("[TB] FAIL reload j=%0d got=%h exp=%h", j, {filling, valid_out, data_out}, expv);
            end
        end
    endtask

    task automatic test_clamp();
        logic [18:0] expv;
        delay_cfg = 5'd0; delay_load = 1'b1;
        tick();
        delay_load = 1'b0;
        checks++;
        if ({filling, delay_active} !== {1'b1, 5'd1}) begin
            failures++;
            $display("[TB] FAIL clamp_low got=%h exp=%h", {filling, delay_active}, {1'b1, 5'd1});
        end
        for (int j = 1; j <= 2; j++) begin
            data_in  = (j == 1) ? 16'h7700 : 16'h0;
            valid_in = (j == 1) ? 2'b10 : 2'b00;
            tick();
            expv = (j == 1) ? {1'b0, 2'b10, 16'h7700} : 19'h0;
            checks++;
            if ({filling, valid_out, data_out} !== expv) begin
                failures++;
                $display("[TB] FAIL clamp_low_out j=%0d got=%h exp=%h", j, {filling, valid_out, data_out}, expv);
            end
        end
        delay_cfg = 5'd31; delay_load = 1'b1;
        tick();
        delay_load = 1'b0;
        checks++;
        if ({filling, delay_active} !== {1'b1, 5'd16}) begin
            failures++;
            $display("[TB] FAIL clamp_high got=%h exp=%h", {filling, delay_active}, {1'b1, 5'd16});
        end
        for (int j = 1; j <= 17; j++) begin
            data_in  = (j == 1) ? 16'h00C3 : 16'h0;
            valid_in = (j == 1) ? 2'b01 : 2'b00;
            tick();
            expv = (j == 16) ? {1'b0, 2'b01, 16'h00C3} : {1'(j < 16), 2'b00, 16'h0000};
            checks++;
            if ({filling, valid_out, data_out} !== expv) begin
                failures++;
                $display("[TB] FAIL clamp_high_out j=%0d got=%h exp=%h", j, {filling, valid_out, data_out}, expv);
            end
        end
    endtask

    task automatic test_reload_during_fill();
        logic [18:0] expv;
        delay_cfg = 5'd9; delay_load = 1'b1;
        tick();
        delay_load = 1'b0;
        tick();
        delay_cfg = 5'd3; delay_load = 1'b1;
        tick();
        delay_load = 1'b0;
        checks++;
        if ({filling, delay_active} !== {1'b1, 5'd3}) begin
            failures++;
            $display("[TB] FAIL refill_load got=%h exp=%h", {filling, delay_active}, {1'b1, 5'd3});
        end
        for (int j = 1; j <= 4; j++) begin
            data_in  = (j == 1) ? 16'h0099 : 16'h0;
            valid_in = (j == 1) ? 2'b01 : 2'b00;
            tick();
            expv = (j == 3) ? {1'b0, 2'b01, 16'h0099} : {1'(j < 3), 2'b00, 16'h0000};
            checks++;
            if ({filling, valid_out, data_out} !== expv) begin
                failures++;
                $display("[TB] FAIL refill j=%0d got=%h exp=%h", j, {filling, valid_out, data_out}, expv);
            end
        end
        // Reloading the same delay from RUN must still gate for a full fill.
        delay_load = 1'b1;
        tick();
        delay_load = 1'b0;
        for (int j = 1; j <= 3; j++) begin
            tick();
            checks++;
            if (filling !== 1'(j < 3)) begin
                failures++;
                $display("[TB] FAIL same_reload j=%0d got=%b exp=%b", j, filling, 1'(j < 3));
            end
        end
    endtask

    task automatic test_reset_midflight();
        logic [23:0] expv;
        data_in = 16'h003C; valid_in = 2'b01;
        tick();
        data_in = 16'h0; valid_in = 2'b00;
        tick();
        reset = 1'b1;
        #1;
        checks++;
        expv = {1'b1, 2'b00, 16'h0000, 5'd4};
        if ({filling, valid_out, data_out, delay_active} !== expv) begin
            failures++;
            $display("[TB] FAIL reset_async got=%h exp=%h", {filling, valid_out, data_out, delay_active}, expv);
        end
        delay_cfg = 5'd9; delay_load = 1'b1;
        tick(); tick();
        checks++;
        if (delay_active !== 5'd4) begin
            failures++;
            $display("[TB] FAIL reset_load_ignored got=%0d exp=4", delay_active);
        end
        delay_load = 1'b0; reset = 1'b0;
        for (int j = 1; j <= 20; j++) begin
            tick();
            checks++;
            if ({filling, valid_out, data_out} !== {1'(j < 4), 2'b00, 16'h0000}) begin
                failures++;
                $display("[TB] FAIL reset_flush j=%0d got=%h exp=%h", j, {filling, valid_out, data_out}, {1'(j < 4), 2'b00, 16'h0000});
            end
        end
    endtask

    task automatic test_lane_independence();
        logic [18:0] expv;
        delay_cfg = 5'd5; delay_load = 1'b1;
        tick();
        delay_load = 1'b0;
        for (int j = 1; j <= 5; j++) begin
            tick();
        end
        checks++;
        if ({filling, delay_active} !== {1'b0, 5'd5}) begin
            failures++;
            $display("[TB] FAIL lanes_setup got=%h exp=%h", {filling, delay_active}, {1'b0, 5'd5});
        end
        for (int j = 0; j <= 8; j++) begin
            data_in  = (j == 0) ? 16'h0011 : ((j == 2) ? 16'h2200 : 16'h0);
            valid_in = (j == 0) ? 2'b01 : ((j == 2) ? 2'b10 : 2'b00);
            tick();
            if (j == 4) begin
                expv = {1'b0, 2'b01, 16'h0011};
            end else if (j == 6) begin
                expv = {1'b0, 2'b10, 16'h2200};
            end else begin
                expv = 19'h0;
            end
            checks++;
            if ({filling, valid_out, data_out} !== expv) begin
                failures++;
                $display("[TB] FAIL lanes j=%0d got=%h exp=%h", j, {filling, valid_out, data_out}, expv);
            end
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog got=timeout exp=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        test_reset();
        test_default_delay();
        test_reload();
        test_clamp();
        test_reload_during_fill();
        test_reset_midflight();
        test_lane_independence();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
